// File: rtl/serial_work_rx.sv
// 8N1 UART receiver that packs 64 host bytes into a 512-bit work frame (midstate + data2).
// Define SERIAL_RX_TIMEOUT_EN to discard a partial packet after TIMEOUT_BITS idle bit periods.
module serial_work_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         RxD,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic         new_work
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CLKS);
`ifdef SERIAL_RX_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta_reg;
  logic          rx_sync_reg;
  state_t        state_reg;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          byte_valid_reg;
  logic          frame_err_reg;
  logic [511:0]  frame_reg;
  logic [5:0]    byte_cnt_reg;
  logic          done_reg;
  logic [IW-1:0] idle_cnt_reg;
  logic          timeout_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= RxD;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Bit-level receiver; byte_valid/frame_err are one-clk strobes at the stop sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      baud_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          bit_idx_reg  <= '0;
          if (!rx_sync_reg) state_reg <= START;
        end
        START: begin
          if (baud_cnt_reg == HALF_CNT) begin
            baud_cnt_reg <= '0;
            state_reg    <= rx_sync_reg ? IDLE : DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_reg == LAST_CNT) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {rx_sync_reg, shift_reg[7:1]};
            bit_idx_reg  <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt_reg == LAST_CNT) begin
            state_reg      <= IDLE;
            byte_valid_reg <= rx_sync_reg;
            frame_err_reg  <= !rx_sync_reg;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Counts clks spent waiting for a start bit since the last byte activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_reg <= '0;
    end else if (state_reg != IDLE || byte_valid_reg) begin
      idle_cnt_reg <= '0;
    end else if (idle_cnt_reg != IDLE_LIMIT) begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = TIMEOUT_EN && (idle_cnt_reg == IDLE_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_reg    <= '0;
      byte_cnt_reg <= '0;
      done_reg     <= 1'b0;
      midstate     <= '0;
      data2        <= '0;
      new_work     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      new_work <= done_reg;
      if (done_reg) begin
        midstate <= frame_reg[511:256];
        data2    <= frame_reg[255:0];
      end
      if (frame_err_reg) begin
        byte_cnt_reg <= '0;
      end else if (byte_valid_reg) begin
        frame_reg    <= {frame_reg[503:0], shift_reg};
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
        if (byte_cnt_reg == 6'd63) done_reg <= 1'b1;
      end else if (timeout_hit && byte_cnt_reg != 6'd0) begin
        byte_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_work_rx.sv
// Directed bench for serial_work_rx at 10 clks/bit: packet table plus corner-case sequences.
module tb_serial_work_rx;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         RxD = 1'b1;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic         new_work;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int wide = 0;
  logic nw_prev = 1'b0;

  always #5 clk = ~clk;

  serial_work_rx #(.CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_BITS(32)) dut (
    .clk(clk), .reset_n(reset_n), .RxD(RxD),
    .midstate(midstate), .data2(data2), .new_work(new_work)
  );

  always @(negedge clk) begin
    if (new_work) pulses++;
    if (new_work && nw_prev) wide++;
    nw_prev = new_work;
  end

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   step;
    logic [255:0] mid;
    logic [255:0] d2;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s", name);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RxD = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (10) @(negedge clk);
    end
    RxD = stop_bit;
    repeat (10) @(negedge clk);
    RxD = 1'b1;
  endtask

  task automatic send_pattern(input logic [7:0] base, input logic [7:0] step, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(int'(step) * i);
      send_byte(b, 1'b1);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int p0;
    vecs[0] = '{8'h00, 8'h01,
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f};
    vecs[1] = '{8'hFF, 8'h00, {256{1'b1}}, {256{1'b1}}};
    vecs[2] = '{8'h80, 8'h01,
      256'h808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e9f,
      256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf};

    // Reset state and idle line
    repeat (3) @(negedge clk);
    check("reset_midstate", midstate, 256'h0);
    check("reset_data2", data2, 256'h0);
    check("reset_new_work", {255'h0, new_work}, 256'h0);
    reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_midstate", midstate, 256'h0);
    check("idle_data2", data2, 256'h0);
    check("idle_pulses", 256'(pulses), 256'h0);

    for (int v = 0; v < 3; v++) begin
      p0 = pulses;
      send_pattern(vecs[v].base, vecs[v].step, 64);
      check($sformatf("vec%0d_pulses", v), 256'(pulses - p0), 256'h1);
      check($sformatf("vec%0d_midstate", v), midstate, vecs[v].mid);
      check($sformatf("vec%0d_data2", v), data2, vecs[v].d2);
    end

    // 63 bytes leave outputs untouched; the 64th completes the packet
    p0 = pulses;
    send_pattern(8'h11, 8'h00, 63);
    check("partial_pulses", 256'(pulses - p0), 256'h0);
    check("partial_midstate", midstate, vecs[2].mid);
    check("partial_data2", data2, vecs[2].d2);
    send_pattern(8'hAA, 8'h00, 1);
    check("byte64_pulses", 256'(pulses - p0), 256'h1);
    check("byte64_last", {248'h0, data2[7:0]}, 256'hAA);
    check("byte64_midstate", midstate, {32{8'h11}});
    check("byte64_data2", data2, {{31{8'h11}}, 8'hAA});

    // Framing error mid-packet resynchronises to packet start
    p0 = pulses;
    send_pattern(8'h77, 8'h00, 5);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    send_pattern(8'h40, 8'h01, 64);
    check("frame_pulses", 256'(pulses - p0), 256'h1);
    check("frame_midstate", midstate,
      256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f);
    check("frame_data2", data2,
      256'h606162636465666768696a6b6c6d6e6f707172737475767778797a7b7c7d7e7f);

    // 3-clk low glitch must not start a byte
    p0 = pulses;
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    repeat (200) @(negedge clk);
    send_pattern(8'h5A, 8'h00, 64);
    check("glitch_pulses", 256'(pulses - p0), 256'h1);
    check("glitch_midstate", midstate, {32{8'h5A}});

    // Partial packet followed by a long idle gap
    p0 = pulses;
    send_pattern(8'h12, 8'h00, 10);
    repeat (400) @(negedge clk);
    send_pattern(8'hFF, 8'h00, 64);
    check("timeout_pulses", 256'(pulses - p0), 256'h1);
`ifdef SERIAL_RX_TIMEOUT_EN
    check("timeout_midstate", midstate, {256{1'b1}});
`else
    check("timeout_midstate", midstate, {{10{8'h12}}, {22{8'hFF}}});
`endif
    check("timeout_data2", data2, {256{1'b1}});

    // Reset mid-packet clears outputs and loses the partial packet
    send_pattern(8'h21, 8'h00, 20);
    reset_n = 1'b0;
    #1;
    check("midrst_midstate", midstate, 256'h0);
    check("midrst_data2", data2, 256'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    p0 = pulses;
    send_pattern(8'h33, 8'h00, 44);
    check("midrst_pulses", 256'(pulses - p0), 256'h0);
    check("midrst_hold", midstate, 256'h0);

    check("pulse_width", 256'(wide), 256'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
